alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 92 +++++++++
 tb/tb_alu_pipe.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes and an iterative shift-add multiplier
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             unknown_op
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] MUL_BUSY = 1'b1;
  logic [0:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt, alu_res;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    shamt;
  logic             alu_unk, is_mul, accept;
  assign shamt    = b[SW-1:0];
  assign is_mul   = MUL_EN && alu_op == 4'd12;
  assign in_ready = state == IDLE && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign acc_nxt  = b_sh[0] ? acc + a_sh : acc;
  always_comb begin
    alu_res = '0;
    alu_unk = 1'b0;
    case (alu_op)
      4'd0:  alu_res = a & b;
      4'd1:  alu_res = a | b;
      4'd2:  alu_res = a + b;
      4'd3:  alu_res = a - b;
      4'd4:  alu_res = {{(WIDTH-1){1'b0}}, a == b};
      4'd5:  alu_res = a;
      4'd6:  alu_res = a ^ b;
      4'd7:  alu_res = a << shamt;
      4'd8:  alu_res = a >> shamt;
      4'd9:  alu_res = $signed(a) >>> shamt;
      4'd10: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'd11: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      default: alu_unk = 1'b1;
    endcase
  end
  // MUL retires on the step that takes cnt from 1 to 0, so the sum of that step goes straight out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      result     <= '0;
      zero       <= 1'b1;
      unknown_op <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else if (state == MUL_BUSY) begin
      acc  <= acc_nxt;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state      <= IDLE;
        result     <= acc_nxt;
        zero       <= acc_nxt == '0;
        unknown_op <= 1'b0;
        out_valid  <= 1'b1;
      end
    end else if (accept && is_mul) begin
      state     <= MUL_BUSY;
      a_sh      <= a;
      b_sh      <= b;
      acc       <= '0;
      cnt       <= CW'(WIDTH);
      out_valid <= 1'b0;
    end else if (accept) begin
      result     <= alu_res;
      zero       <= alu_res == '0;
      unknown_op <= alu_unk;
      out_valid  <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random checks of alu_pipe against an arithmetic reference model
module tb_alu_pipe;
  logic        clk, reset, in_valid, out_ready;
  logic [3:0]  alu_op;
  logic [31:0] a, b;
  logic        in_ready, out_valid, zero, unknown_op;
  logic [31:0] result;
  logic        nm_in_ready, nm_out_valid, nm_zero, nm_unknown_op;
  logic [31:0] nm_result;
  int checks = 0;
  int failures = 0;

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .unknown_op(unknown_op)
  );
  alu_pipe #(.WIDTH(32), .MUL_EN(1'b0)) u_nm (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nm_in_ready), .alu_op(alu_op),
    .a(a), .b(b), .out_valid(nm_out_valid), .out_ready(out_ready), .result(nm_result),
    .zero(nm_zero), .unknown_op(nm_unknown_op)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {unknown, result} computed straight from the opcode table
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [4:0]  s;
    logic [63:0] p;
    s = y[4:0];
    p = {32'b0, x} * {32'b0, y};
    case (op)
      4'd0:  return {1'b0, x & y};
      4'd1:  return {1'b0, x | y};
      4'd2:  return {1'b0, x + y};
      4'd3:  return {1'b0, x - y};
      4'd4:  return {1'b0, 32'(x == y)};
      4'd5:  return {1'b0, x};
      4'd6:  return {1'b0, x ^ y};
      4'd7:  return {1'b0, x << s};
      4'd8:  return {1'b0, x >> s};
      4'd9:  return {1'b0, x[31] ? ~(~x >> s) : (x >> s)};
      4'd10: return {1'b0, 32'(int'(x) < int'(y))};
      4'd11: return {1'b0, 32'(x < y)};
      4'd12: return {1'b0, p[31:0]};
      default: return {1'b1, 32'b0};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [32:0] m;
    m = model(op, x, y);
    alu_op = op; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    chk("op_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; a = ~x; b = ~y;
    chk("op_out_valid", 32'(out_valid), 32'd1);
    chk("op_result", result, m[31:0]);
    chk("op_zero", 32'(zero), 32'(m[31:0] == 32'd0));
    chk("op_unknown", 32'(unknown_op), 32'(m[32]));
  endtask

  task automatic do_mul(input logic [31:0] x, input logic [31:0] y);
    logic [32:0] m;
    int n;
    m = model(4'd12, x, y);
    alu_op = 4'd12; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    chk("mul_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; a = ~x; b = ~y; alu_op = 4'd0;
    chk("nomul_unknown", 32'(nm_unknown_op), 32'd1);
    chk("nomul_result", nm_result, 32'd0);
    chk("nomul_valid", 32'(nm_out_valid), 32'd1);
    n = 0;
    while (!out_valid && n < 100) begin
      chk("mul_busy_ready", 32'(in_ready), 32'd0);
      tick();
      n++;
    end
    chk("mul_latency", 32'(n), 32'd32);
    chk("mul_result", result, m[31:0]);
    chk("mul_zero", 32'(zero), 32'(m[31:0] == 32'd0));
    chk("mul_unknown", 32'(unknown_op), 32'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] x, y;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_op = 4'd0; a = '0; b = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_unknown", 32'(unknown_op), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    do_op(4'd2, 32'hFFFF_FFFF, 32'd1);
    do_op(4'd9, 32'h8000_0000, 32'h21);
    chk("sra_value", result, 32'hC000_0000);
    do_op(4'd10, 32'hFFFF_FFFF, 32'd1);
    chk("slt_value", result, 32'd1);
    do_op(4'd11, 32'hFFFF_FFFF, 32'd1);
    chk("sltu_value", result, 32'd0);
    do_mul(32'd7, 32'd6);
    chk("mul42", result, 32'd42);
    do_mul(32'h1_0000, 32'h1_0000);
    chk("mul_wrap_zero", 32'(zero), 32'd1);
    // backpressure: result held, new op accepted on the drain cycle
    do_op(4'd2, 32'd3, 32'd4);
    out_ready = 1'b0; alu_op = 4'd2; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_result_held", result, 32'd7);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_new_valid", 32'(out_valid), 32'd1);
    chk("bp_new_result", result, 32'd2);
    tick();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_result_hold", result, 32'd2);
    do_op(4'd14, 32'h1234_5678, 32'h9ABC_DEF0);
    chk("unknown14", 32'(unknown_op), 32'd1);
    // reset in the middle of a multiply
    alu_op = 4'd12; a = 32'd5; b = 32'd9; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_zero", 32'(zero), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (40) tick();
    chk("midrst_no_stale_valid", 32'(out_valid), 32'd0);
    chk("midrst_no_stale_result", result, 32'd0);
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      if (op == 4'd12) do_mul(x, y);
      else do_op(op, x, y);
      if ($urandom_range(0, 1) == 1) tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
